// File: rtl/f9pcap_rx_hdr_strip.sv
// f9pcap receive header stripper: checks the 58-byte eth/ip/udp/f9pcap
// header and forwards the payload. Define F9PCAP_RX_HDR_STRIP_STATS_EN for counters.
module f9pcap_rx_hdr_strip #(
  parameter int DATA_WIDTH = 8,
  parameter int TTS_WIDTH  = 56,
  parameter int HDR_LENGTH = 58,
  parameter int CNT_WIDTH  = 32
) (
  input  logic                  clk_in,
  input  logic                  rst_n_in,
  input  logic [31:0]           mcgroup_addr,
  input  logic [15:0]           mcgroup_port,
  input  logic                  rx_valid_in,
  output logic                  rx_ready_out,
  input  logic [DATA_WIDTH-1:0] rx_data_in,
  input  logic                  rx_last_in,
  output logic                  pl_valid_out,
  input  logic                  pl_ready_in,
  output logic [DATA_WIDTH-1:0] pl_data_out,
  output logic                  pl_last_out,
  output logic                  pl_err_out,
  output logic [TTS_WIDTH-1:0]  pl_tts_out,
  output logic [7:0]            pl_sfp_idx_out
`ifdef F9PCAP_RX_HDR_STRIP_STATS_EN
  ,
  output logic [CNT_WIDTH-1:0]  stat_ok_cnt_out,
  output logic [CNT_WIDTH-1:0]  stat_drop_cnt_out,
  output logic [CNT_WIDTH-1:0]  stat_lenerr_cnt_out
`endif
);

  localparam int CW = 6;
  localparam logic [CW-1:0] HDR_LAST = CW'(HDR_LENGTH - 1);

  typedef enum logic [1:0] {
    S_HDR,
    S_PAYLOAD,
    S_DROP
  } state_e;

  state_e                state_q, state_d;
  logic [CW-1:0]         hdr_cnt_q, hdr_cnt_d;
  logic                  match_q, match_d;
  logic [TTS_WIDTH-1:0]  tts_sh_q, tts_sh_d;
  logic [7:0]            sfp_sh_q, sfp_sh_d;
  logic [15:0]           len_q, len_d;
  logic [TTS_WIDTH-1:0]  tts_q, tts_d;
  logic [7:0]            sfp_q, sfp_d;
  logic [15:0]           pcnt_q, pcnt_d;
  logic                  pl_valid_q, pl_valid_d;
  logic [DATA_WIDTH-1:0] pl_data_q, pl_data_d;
  logic                  pl_last_q, pl_last_d;
  logic                  pl_err_q, pl_err_d;
  logic                  rdy;
  logic                  acc;
  logic                  byte_ok;
  logic                  pl_free;
  logic                  len_bad;

`ifdef F9PCAP_RX_HDR_STRIP_STATS_EN
  logic [CNT_WIDTH-1:0]  ok_q, ok_d;
  logic [CNT_WIDTH-1:0]  drop_q, drop_d;
  logic [CNT_WIDTH-1:0]  lenerr_q, lenerr_d;
`endif

  // Per-offset header field check against the configured group
  always_comb begin
    byte_ok = 1'b1;
    unique case (hdr_cnt_q)
      6'd0:    byte_ok = (rx_data_in == 8'h01);
      6'd1:    byte_ok = (rx_data_in == 8'h00);
      6'd2:    byte_ok = (rx_data_in == 8'h5E);
      6'd3:    byte_ok = (rx_data_in == {1'b0, mcgroup_addr[22:16]});
      6'd4:    byte_ok = (rx_data_in == mcgroup_addr[15:8]);
      6'd5:    byte_ok = (rx_data_in == mcgroup_addr[7:0]);
      6'd12:   byte_ok = (rx_data_in == 8'h08);
      6'd13:   byte_ok = (rx_data_in == 8'h00);
      6'd14:   byte_ok = (rx_data_in == 8'h45);
      6'd23:   byte_ok = (rx_data_in == 8'h11);
      6'd30:   byte_ok = (rx_data_in == mcgroup_addr[31:24]);
      6'd31:   byte_ok = (rx_data_in == mcgroup_addr[23:16]);
      6'd32:   byte_ok = (rx_data_in == mcgroup_addr[15:8]);
      6'd33:   byte_ok = (rx_data_in == mcgroup_addr[7:0]);
      6'd36:   byte_ok = (rx_data_in == mcgroup_port[15:8]);
      6'd37:   byte_ok = (rx_data_in == mcgroup_port[7:0]);
      default: byte_ok = 1'b1;
    endcase
  end

  // Next-state, header capture, payload output stage and handshake
  always_comb begin
    state_d    = state_q;
    hdr_cnt_d  = hdr_cnt_q;
    match_d    = match_q;
    tts_sh_d   = tts_sh_q;
    sfp_sh_d   = sfp_sh_q;
    len_d      = len_q;
    tts_d      = tts_q;
    sfp_d      = sfp_q;
    pcnt_d     = pcnt_q;
    pl_valid_d = pl_valid_q;
    pl_data_d  = pl_data_q;
    pl_last_d  = pl_last_q;
    pl_err_d   = pl_err_q;
    len_bad    = 1'b0;
`ifdef F9PCAP_RX_HDR_STRIP_STATS_EN
    ok_d       = ok_q;
    drop_d     = drop_q;
    lenerr_d   = lenerr_q;
`endif
    pl_free = !pl_valid_q || pl_ready_in;
    unique case (state_q)
      S_PAYLOAD: rdy = pl_free;
      default:   rdy = 1'b1;
    endcase
    acc = rx_valid_in && rdy && rst_n_in;

    if (pl_valid_q && pl_ready_in) begin
      pl_valid_d = 1'b0;
      pl_last_d  = 1'b0;
      pl_err_d   = 1'b0;
    end

    if (acc) begin
      unique case (state_q)
        S_HDR: begin
          match_d = ((hdr_cnt_q == '0) || match_q) && byte_ok;
          if (hdr_cnt_q >= 6'd42 && hdr_cnt_q <= 6'd48)
            tts_sh_d = {tts_sh_q[TTS_WIDTH-DATA_WIDTH-1:0], rx_data_in};
          if (hdr_cnt_q == 6'd49) sfp_sh_d = rx_data_in;
          if (hdr_cnt_q == 6'd50) len_d[15:8] = rx_data_in;
          if (hdr_cnt_q == 6'd51) len_d[7:0] = rx_data_in;
          if (rx_last_in) begin
            hdr_cnt_d = '0;
`ifdef F9PCAP_RX_HDR_STRIP_STATS_EN
            drop_d = drop_q + 1'b1;
`endif
          end else if (hdr_cnt_q == HDR_LAST) begin
            hdr_cnt_d = '0;
            pcnt_d    = '0;
            if (match_d) begin
              state_d = S_PAYLOAD;
              tts_d   = tts_sh_q;
              sfp_d   = sfp_sh_q;
            end else begin
              state_d = S_DROP;
            end
          end else begin
            hdr_cnt_d = hdr_cnt_q + 1'b1;
          end
        end
        S_PAYLOAD: begin
          pl_valid_d = 1'b1;
          pl_data_d  = rx_data_in;
          pl_last_d  = rx_last_in;
          pl_err_d   = 1'b0;
          if (pcnt_q != 16'hFFFF) pcnt_d = pcnt_q + 1'b1;
          if (rx_last_in) begin
            len_bad = (pcnt_q == 16'hFFFF) ||
                      (({1'b0, pcnt_q} + 17'd1) != {1'b0, len_q});
            pl_err_d  = len_bad;
            state_d   = S_HDR;
            hdr_cnt_d = '0;
`ifdef F9PCAP_RX_HDR_STRIP_STATS_EN
            if (len_bad) lenerr_d = lenerr_q + 1'b1;
            else         ok_d     = ok_q + 1'b1;
`endif
          end
        end
        S_DROP: begin
          if (rx_last_in) begin
            state_d   = S_HDR;
            hdr_cnt_d = '0;
`ifdef F9PCAP_RX_HDR_STRIP_STATS_EN
            drop_d = drop_q + 1'b1;
`endif
          end
        end
        default: state_d = S_HDR;
      endcase
    end
  end

  // State and datapath registers with synchronous reset
  always_ff @(posedge clk_in) begin
    if (!rst_n_in) begin
      state_q    <= S_HDR;
      hdr_cnt_q  <= '0;
      match_q    <= 1'b0;
      tts_sh_q   <= '0;
      sfp_sh_q   <= '0;
      len_q      <= '0;
      tts_q      <= '0;
      sfp_q      <= '0;
      pcnt_q     <= '0;
      pl_valid_q <= 1'b0;
      pl_data_q  <= '0;
      pl_last_q  <= 1'b0;
      pl_err_q   <= 1'b0;
`ifdef F9PCAP_RX_HDR_STRIP_STATS_EN
      ok_q       <= '0;
      drop_q     <= '0;
      lenerr_q   <= '0;
`endif
    end else begin
      state_q    <= state_d;
      hdr_cnt_q  <= hdr_cnt_d;
      match_q    <= match_d;
      tts_sh_q   <= tts_sh_d;
      sfp_sh_q   <= sfp_sh_d;
      len_q      <= len_d;
      tts_q      <= tts_d;
      sfp_q      <= sfp_d;
      pcnt_q     <= pcnt_d;
      pl_valid_q <= pl_valid_d;
      pl_data_q  <= pl_data_d;
      pl_last_q  <= pl_last_d;
      pl_err_q   <= pl_err_d;
`ifdef F9PCAP_RX_HDR_STRIP_STATS_EN
      ok_q       <= ok_d;
      drop_q     <= drop_d;
      lenerr_q   <= lenerr_d;
`endif
    end
  end

  assign rx_ready_out   = rdy && rst_n_in;
  assign pl_valid_out   = pl_valid_q;
  assign pl_data_out    = pl_data_q;
  assign pl_last_out    = pl_last_q;
  assign pl_err_out     = pl_err_q;
  assign pl_tts_out     = tts_q;
  assign pl_sfp_idx_out = sfp_q;

`ifdef F9PCAP_RX_HDR_STRIP_STATS_EN
  assign stat_ok_cnt_out     = ok_q;
  assign stat_drop_cnt_out   = drop_q;
  assign stat_lenerr_cnt_out = lenerr_q;
`endif

endmodule

// File: tb/tb_f9pcap_rx_hdr_strip.sv
// Directed bench for f9pcap_rx_hdr_strip: builds frames byte by byte,
// collects payload beats and checks them against hand-derived values.
module tb_f9pcap_rx_hdr_strip;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] mc_addr;
  logic [15:0] mc_port;
  logic        rx_valid;
  logic        rx_ready;
  logic [7:0]  rx_data;
  logic        rx_last;
  logic        pl_valid;
  logic        pl_ready;
  logic [7:0]  pl_data;
  logic        pl_last;
  logic        pl_err;
  logic [55:0] pl_tts;
  logic [7:0]  pl_sfp;
`ifdef F9PCAP_RX_HDR_STRIP_STATS_EN
  logic [31:0] st_ok;
  logic [31:0] st_drop;
  logic [31:0] st_lenerr;
`endif

  f9pcap_rx_hdr_strip dut (
    .clk_in         (clk),
    .rst_n_in       (rst_n),
    .mcgroup_addr   (mc_addr),
    .mcgroup_port   (mc_port),
    .rx_valid_in    (rx_valid),
    .rx_ready_out   (rx_ready),
    .rx_data_in     (rx_data),
    .rx_last_in     (rx_last),
    .pl_valid_out   (pl_valid),
    .pl_ready_in    (pl_ready),
    .pl_data_out    (pl_data),
    .pl_last_out    (pl_last),
    .pl_err_out     (pl_err),
    .pl_tts_out     (pl_tts),
    .pl_sfp_idx_out (pl_sfp)
`ifdef F9PCAP_RX_HDR_STRIP_STATS_EN
    ,
    .stat_ok_cnt_out     (st_ok),
    .stat_drop_cnt_out   (st_drop),
    .stat_lenerr_cnt_out (st_lenerr)
`endif
  );

  typedef struct {
    logic [7:0]  d;
    logic        l;
    logic        e;
    logic [55:0] t;
    logic [7:0]  s;
  } beat_t;

  beat_t      bq[$];
  logic [7:0] frm[$];
  int         nchk = 0;
  int         nerr = 0;
  int         nrdy = 0;
  bit         stall_en = 1'b0;

  initial forever #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
    nchk++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Sink: randomised or constant ready, beats captured at negedge
  initial begin
    pl_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      pl_ready = stall_en ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  initial forever begin
    @(negedge clk);
    if (rst_n && pl_valid && pl_ready)
      bq.push_back('{pl_data, pl_last, pl_err, pl_tts, pl_sfp});
  end

  task automatic build(input logic [31:0] a, input logic [15:0] p,
                       input logic [15:0] len, input logic [55:0] tts,
                       input logic [7:0] idx, input int n,
                       input logic [7:0] start);
    frm.delete();
    frm.push_back(8'h01); frm.push_back(8'h00); frm.push_back(8'h5E);
    frm.push_back({1'b0, a[22:16]});
    frm.push_back(a[15:8]); frm.push_back(a[7:0]);
    for (int i = 6; i < 12; i++) frm.push_back(8'h02 + 8'(i));
    frm.push_back(8'h08); frm.push_back(8'h00);
    frm.push_back(8'h45);
    for (int i = 15; i < 23; i++) frm.push_back(8'h00);
    frm.push_back(8'h11);
    for (int i = 24; i < 30; i++) frm.push_back(8'hC0);
    frm.push_back(a[31:24]); frm.push_back(a[23:16]);
    frm.push_back(a[15:8]); frm.push_back(a[7:0]);
    frm.push_back(8'h12); frm.push_back(8'h34);
    frm.push_back(p[15:8]); frm.push_back(p[7:0]);
    for (int i = 38; i < 42; i++) frm.push_back(8'h00);
    for (int i = 6; i >= 0; i--) frm.push_back(tts[i*8 +: 8]);
    frm.push_back(idx);
    frm.push_back(len[15:8]); frm.push_back(len[7:0]);
    for (int i = 52; i < 58; i++) frm.push_back(8'h00);
    for (int i = 0; i < n; i++) frm.push_back(start + 8'(i));
  endtask

  task automatic send(input int rst_at);
    bit acc;
    int w;
    for (int i = 0; i < frm.size(); i++) begin
      if (i == rst_at) begin
        rx_valid = 1'b0;
        rx_last  = 1'b0;
        rst_n    = 1'b0;
        @(negedge clk);
        check("rst rx_ready", rx_ready, 1'b0);
        @(posedge clk);
        #1;
        check("rst pl_valid", pl_valid, 1'b0);
        check("rst rx_ready2", rx_ready, 1'b0);
        check("rst pl_data", pl_data, 8'h00);
        check("rst pl_last", {pl_last, pl_err}, 2'b00);
        check("rst pl_tts", pl_tts, 56'h0);
        check("rst pl_sfp", pl_sfp, 8'h00);
        rst_n = 1'b1;
        return;
      end
      rx_valid = 1'b1;
      rx_data  = frm[i];
      rx_last  = (i == frm.size() - 1);
      w = 0;
      do begin
        @(negedge clk);
        acc = rx_ready;
        if (!acc) nrdy++;
        @(posedge clk);
        #1;
        w++;
      end while (!acc && w < 2000);
      if (!acc) begin
        check("send timeout", 1'b0, 1'b1);
        break;
      end
    end
    rx_valid = 1'b0;
    rx_last  = 1'b0;
  endtask

  task automatic drain();
    int w = 0;
    do begin
      @(negedge clk);
      w++;
    end while (pl_valid && w < 2000);
    if (pl_valid) check("drain timeout", 1'b0, 1'b1);
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic verify(input string tag, input logic [7:0] start,
                        input int n, input logic err,
                        input logic [55:0] tts, input logic [7:0] idx);
    beat_t b;
    int bd = 0;
    int bl = 0;
    int bt = 0;
    if (bq.size() < n) begin
      check({tag, " beats"}, 64'(bq.size()), 64'(n));
      bq.delete();
      return;
    end
    for (int i = 0; i < n; i++) begin
      b = bq.pop_front();
      if (b.d !== start + 8'(i)) bd++;
      if (i < n - 1 && (b.l !== 1'b0 || b.e !== 1'b0)) bl++;
      if (b.t !== tts || b.s !== idx) bt++;
      if (i == n - 1) begin
        check({tag, " last"}, b.l, 1'b1);
        check({tag, " err"}, b.e, err);
        check({tag, " tts"}, b.t, tts);
        check({tag, " sfp"}, b.s, idx);
      end
    end
    check({tag, " data bad"}, 64'(bd), 64'd0);
    check({tag, " early last"}, 64'(bl), 64'd0);
    check({tag, " tts unstable"}, 64'(bt), 64'd0);
  endtask

  localparam logic [31:0] GA = 32'h01020304;
  localparam logic [15:0] GP = 16'h0506;
  localparam logic [55:0] T1 = 56'h11223344556677;
  localparam logic [55:0] T2 = 56'hA1A2A3A4A5A6A7;

  initial begin
    rst_n    = 1'b0;
    mc_addr  = GA;
    mc_port  = GP;
    rx_valid = 1'b0;
    rx_data  = 8'h00;
    rx_last  = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset pl_valid", pl_valid, 1'b0);
    check("reset rx_ready", rx_ready, 1'b0);
    check("reset tts", pl_tts, 56'h0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("idle rx_ready", rx_ready, 1'b1);

    build(GA, GP, 16'd64, T1, 8'd1, 64, 8'h00);
    send(-1);
    drain();
    check("f1 count", 64'(bq.size()), 64'd64);
    verify("f1", 8'h00, 64, 1'b0, T1, 8'd1);
    check("f1 tts out", pl_tts, T1);
`ifdef F9PCAP_RX_HDR_STRIP_STATS_EN
    check("f1 ok cnt", st_ok, 32'd1);
`endif

    nrdy = 0;
    build(GA, 16'h0507, 16'd64, T1, 8'd1, 64, 8'h00);
    send(-1);
    drain();
    check("port mm beats", 64'(bq.size()), 64'd0);
    check("port mm not ready", 64'(nrdy), 64'd0);
`ifdef F9PCAP_RX_HDR_STRIP_STATS_EN
    check("port mm drop cnt", st_drop, 32'd1);
`endif

    build(GA, GP, 16'd64, T1, 8'd1, 63, 8'h00);
    send(-1);
    drain();
    check("lenerr count", 64'(bq.size()), 64'd63);
    verify("lenerr", 8'h00, 63, 1'b1, T1, 8'd1);
`ifdef F9PCAP_RX_HDR_STRIP_STATS_EN
    check("lenerr cnt", st_lenerr, 32'd1);
`endif

    build(GA, GP, 16'd64, T1, 8'd1, 64, 8'h00);
    frm = frm[0:39];
    send(-1);
    drain();
    check("runt beats", 64'(bq.size()), 64'd0);
`ifdef F9PCAP_RX_HDR_STRIP_STATS_EN
    check("runt drop cnt", st_drop, 32'd2);
`endif
    build(GA, GP, 16'd16, T2, 8'd3, 16, 8'h80);
    send(-1);
    drain();
    check("post runt count", 64'(bq.size()), 64'd16);
    verify("post runt", 8'h80, 16, 1'b0, T2, 8'd3);

    stall_en = 1'b1;
    build(GA, GP, 16'd64, T1, 8'd1, 64, 8'h00);
    send(-1);
    build(GA, GP, 16'd64, T2, 8'd2, 64, 8'h40);
    send(-1);
    drain();
    stall_en = 1'b0;
    check("stall count", 64'(bq.size()), 64'd128);
    verify("stall a", 8'h00, 64, 1'b0, T1, 8'd1);
    verify("stall b", 8'h40, 64, 1'b0, T2, 8'd2);
`ifdef F9PCAP_RX_HDR_STRIP_STATS_EN
    check("stall ok cnt", st_ok, 32'd4);
`endif

    build(GA, GP, 16'd64, T1, 8'd1, 64, 8'h00);
    send(58 + 20);
    repeat (5) @(posedge clk);
    #1;
    check("post rst valid", pl_valid, 1'b0);
    bq.delete();
    build(GA, GP, 16'd32, T2, 8'd5, 32, 8'h20);
    send(-1);
    drain();
    check("clean count", 64'(bq.size()), 64'd32);
    verify("clean", 8'h20, 32, 1'b0, T2, 8'd5);
`ifdef F9PCAP_RX_HDR_STRIP_STATS_EN
    check("clean ok cnt", st_ok, 32'd1);
`endif

    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end

endmodule
